// File: rtl/clause_bin_loader.sv
// Moves one clause bin between external memory and the clause array.
// Load: memory -> array through wr_o; store: array -> memory through rd_o.
module clause_bin_loader #(
  parameter int NUM_CLAUSES = 8,
  parameter int NUM_VARS    = 8,
  parameter int WIDTH_C_LEN = 4,
  parameter int WIDTH_ADDR  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_load_i,
  input  logic                   start_store_i,
  input  logic [WIDTH_ADDR-1:0]  base_addr_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   mem_rd_o,
  output logic [WIDTH_ADDR-1:0]  mem_addr_o,
  input  logic                   mem_valid_i,
  input  logic [NUM_VARS*2-1:0]  mem_data_i,
  input  logic [WIDTH_C_LEN-1:0] mem_len_i,
  output logic                   mem_wr_o,
  output logic [NUM_VARS*2-1:0]  mem_wdata_o,
  input  logic                   mem_ready_i,
  output logic [NUM_CLAUSES-1:0] wr_o,
  output logic [NUM_CLAUSES-1:0] rd_o,
  output logic [NUM_VARS*2-1:0]  clause_o,
  output logic [WIDTH_C_LEN-1:0] clause_len_o,
  input  logic [NUM_VARS*2-1:0]  clause_i
);

  localparam int W_K = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
  localparam int W_D = NUM_VARS * 2;

  typedef enum logic [2:0] {
    S_IDLE, S_LD_REQ, S_LD_WAIT, S_LD_WR, S_ST_RD, S_ST_WR, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [W_K-1:0]         k_q, k_d;
  logic [WIDTH_ADDR-1:0]  base_q, base_d;
  // Shared holding register: loaded word on load, array read-back on store.
  logic [W_D-1:0]         data_q, data_d;
  logic [WIDTH_C_LEN-1:0] len_q, len_d;
  logic                   last_k;
  logic [NUM_CLAUSES-1:0] k_onehot;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      base_q  <= '0;
      data_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      base_q  <= base_d;
      data_q  <= data_d;
      len_q   <= len_d;
    end
  end

  assign last_k   = (k_q == W_K'(NUM_CLAUSES - 1));
  assign k_onehot = NUM_CLAUSES'(1) << k_q;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    base_d       = base_q;
    data_d       = data_q;
    len_d        = len_q;
    busy_o       = (state_q != S_IDLE);
    done_o       = 1'b0;
    mem_rd_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wr_o     = 1'b0;
    mem_wdata_o  = '0;
    wr_o         = '0;
    rd_o         = '0;
    clause_o     = '0;
    clause_len_o = '0;

    if (state_q != S_IDLE) mem_addr_o = base_q + WIDTH_ADDR'(k_q);

    case (state_q)
      S_IDLE: begin
        if (start_load_i || start_store_i) begin
          k_d     = '0;
          base_d  = base_addr_i;
          state_d = start_load_i ? S_LD_REQ : S_ST_RD;
        end
      end
      S_LD_REQ: begin
        mem_rd_o = 1'b1;
        state_d  = S_LD_WAIT;
      end
      S_LD_WAIT: begin
        if (mem_valid_i) begin
          data_d  = mem_data_i;
          len_d   = mem_len_i;
          state_d = S_LD_WR;
        end
      end
      S_LD_WR: begin
        wr_o         = k_onehot;
        clause_o     = data_q;
        clause_len_o = len_q;
        if (last_k) state_d = S_DONE;
        else begin
          k_d     = k_q + 1'b1;
          state_d = S_LD_REQ;
        end
      end
      S_ST_RD: begin
        rd_o    = k_onehot;
        data_d  = clause_i;
        state_d = S_ST_WR;
      end
      S_ST_WR: begin
        mem_wr_o    = 1'b1;
        mem_wdata_o = data_q;
        if (mem_ready_i) begin
          if (last_k) state_d = S_DONE;
          else begin
            k_d     = k_q + 1'b1;
            state_d = S_ST_RD;
          end
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_clause_bin_loader.sv
// Directed bench for clause_bin_loader: models memory and the clause array,
// records every strobe per cycle and compares against hand-computed schedules.
module tb_clause_bin_loader;

  logic        clk = 1'b0;
  logic        rst, start_load_i, start_store_i;
  logic [15:0] base_addr_i;
  logic        busy_o, done_o, mem_rd_o, mem_valid_i, mem_wr_o, mem_ready_i;
  logic [15:0] mem_addr_o, mem_data_i, mem_wdata_o, clause_o, clause_i;
  logic [3:0]  mem_len_i, clause_len_o;
  logic [7:0]  wr_o, rd_o;

  always #5 clk = ~clk;

  clause_bin_loader dut (
    .clk(clk), .rst(rst), .start_load_i(start_load_i), .start_store_i(start_store_i),
    .base_addr_i(base_addr_i), .busy_o(busy_o), .done_o(done_o), .mem_rd_o(mem_rd_o),
    .mem_addr_o(mem_addr_o), .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i),
    .mem_len_i(mem_len_i), .mem_wr_o(mem_wr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .wr_o(wr_o), .rd_o(rd_o), .clause_o(clause_o),
    .clause_len_o(clause_len_o), .clause_i(clause_i)
  );

  int tests_run = 0;
  int tests_failed = 0;

  int          n_wr, n_rd, n_mr, n_mw, n_done, done_cyc, viol, stall_bad, busy_after;
  int          wr_cyc[16];
  logic [7:0]  wr_val[16], rd_val[16];
  logic [15:0] wr_cl[16], mr_addr[16], mw_addr[16], mw_data[16];
  logic [3:0]  wr_len[16];
  logic [9:0]  snap;
  logic [15:0] arr[8];

  function automatic logic [15:0] word_of(input int i);
    return 16'(32'h1111 * (i + 1));
  endfunction

  function automatic int oh_idx(input logic [7:0] v);
    int r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [9:0] out_vec();
    return {busy_o, done_o, mem_rd_o, mem_wr_o, |mem_addr_o, |mem_wdata_o,
            |wr_o, |rd_o, |clause_o, |clause_len_o};
  endfunction

  // Runs one operation starting at the current negedge (cycle 0) and records
  // what the DUT does each cycle until one cycle after done_o (or abort).
  task automatic run_op(input logic ld, input logic st, input logic [15:0] base,
                        input int ext_clause, input int ext, input int wst_clause,
                        input int pulse_at, input int rst_at);
    bit pend = 0;
    int pend_w = 0, pend_idx = 0, wst_cnt = 0, widx;
    n_wr = 0; n_rd = 0; n_mr = 0; n_mw = 0; n_done = 0; done_cyc = -1;
    viol = 0; stall_bad = 0; busy_after = -1; snap = '1;
    start_load_i = ld; start_store_i = st; base_addr_i = base;
    for (int c = 1; c < 400; c++) begin
      @(negedge clk);
      start_load_i  = 1'b0;
      start_store_i = (c == pulse_at);
      if (rst_at >= 0 && c == rst_at + 1) begin
        snap = out_vec();
        rst  = 1'b0;
        pend = 0;
      end
      if (rst_at >= 0 && c == rst_at + 6) break;
      if (wr_o != 0) begin
        if (n_wr < 16) begin
          wr_cyc[n_wr] = c; wr_val[n_wr] = wr_o;
          wr_cl[n_wr] = clause_o; wr_len[n_wr] = clause_len_o;
        end
        arr[oh_idx(wr_o)] = clause_o;
        n_wr++;
      end
      if (rd_o != 0) begin
        if (n_rd < 16) rd_val[n_rd] = rd_o;
        clause_i = arr[oh_idx(rd_o)];
        n_rd++;
      end else clause_i = '0;
      if ((wr_o != 0 && rd_o != 0) || !$onehot0(wr_o) || !$onehot0(rd_o)) viol++;
      if (wr_o == 0 && (clause_o != 0 || clause_len_o != 0)) viol++;
      if (!busy_o && mem_addr_o != 0) viol++;
      mem_valid_i = 1'b0; mem_data_i = 16'hDEAD; mem_len_i = 4'hF;
      if (pend) begin
        pend_w--;
        if (pend_w == 0) begin
          mem_valid_i = 1'b1; mem_data_i = word_of(pend_idx);
          mem_len_i = 4'(pend_idx); pend = 0;
        end
      end
      if (mem_rd_o) begin
        if (n_mr < 16) mr_addr[n_mr] = mem_addr_o;
        pend = 1; pend_idx = n_mr;
        pend_w = 1 + ((n_mr == ext_clause) ? ext : 0);
        n_mr++;
      end
      mem_ready_i = 1'b1;
      if (mem_wr_o) begin
        widx = int'(16'(mem_addr_o - base));
        if (widx == wst_clause && wst_cnt < 3) begin
          mem_ready_i = 1'b0; wst_cnt++;
          if (mem_wdata_o !== word_of(widx)) stall_bad++;
        end else begin
          if (n_mw < 16) begin mw_addr[n_mw] = mem_addr_o; mw_data[n_mw] = mem_wdata_o; end
          n_mw++;
        end
      end
      if (done_o) begin n_done++; done_cyc = c; end
      if (rst_at >= 0 && c == rst_at) rst = 1'b1;
      if (n_done > 0 && c == done_cyc + 1) begin busy_after = int'(busy_o); break; end
    end
    mem_valid_i = 1'b0; start_store_i = 1'b0; mem_ready_i = 1'b1; clause_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_load_i = 0; start_store_i = 0; base_addr_i = 16'h1234;
    mem_valid_i = 0; mem_data_i = 16'hFFFF; mem_len_i = 4'hF; mem_ready_i = 1; clause_i = 16'hFFFF;
    repeat (3) @(negedge clk);
    tests_run++;
    if (out_vec() !== 10'b0) begin tests_failed++; $display("FAIL reset_outputs: got %b exp 0", out_vec()); end
    tests_run++;
    if (mem_addr_o !== 16'h0) begin tests_failed++; $display("FAIL reset_addr: got %h exp 0000", mem_addr_o); end
    rst = 1'b0; clause_i = '0;
  endtask

  task automatic test_load();
    run_op(1, 0, 16'h0100, -1, 0, -1, -1, -1);
    tests_run++;
    if (n_wr !== 8) begin tests_failed++; $display("FAIL load_nwr: got %0d exp 8", n_wr); end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (wr_val[i] !== 8'(1 << i) || wr_cyc[i] !== 3*i+3 || wr_cl[i] !== word_of(i) || wr_len[i] !== 4'(i)) begin
        tests_failed++;
        $display("FAIL load_row%0d: got wr=%h cyc=%0d cl=%h len=%0d exp wr=%h cyc=%0d cl=%h len=%0d",
                 i, wr_val[i], wr_cyc[i], wr_cl[i], wr_len[i], 8'(1 << i), 3*i+3, word_of(i), i);
      end
      tests_run++;
      if (mr_addr[i] !== 16'h0100 + 16'(i)) begin tests_failed++; $display("FAIL load_addr%0d: got %h exp %h", i, mr_addr[i], 16'h0100 + 16'(i)); end
    end
    tests_run++;
    if (n_done !== 1 || done_cyc !== 25) begin tests_failed++; $display("FAIL load_done: got n=%0d cyc=%0d exp n=1 cyc=25", n_done, done_cyc); end
    tests_run++;
    if (busy_after !== 0) begin tests_failed++; $display("FAIL load_busy_fall: got %0d exp 0", busy_after); end
    tests_run++;
    if (viol !== 0 || n_rd !== 0 || n_mw !== 0) begin tests_failed++; $display("FAIL load_strobes: got viol=%0d rd=%0d mw=%0d exp 0 0 0", viol, n_rd, n_mw); end
  endtask

  task automatic test_store_back_to_back();
    run_op(0, 1, 16'h0100, -1, 0, -1, -1, -1);
    tests_run++;
    if (n_rd !== 8 || n_mw !== 8 || n_wr !== 0) begin tests_failed++; $display("FAIL store_counts: got rd=%0d mw=%0d wr=%0d exp 8 8 0", n_rd, n_mw, n_wr); end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (rd_val[i] !== 8'(1 << i) || mw_addr[i] !== 16'h0100 + 16'(i) || mw_data[i] !== word_of(i)) begin
        tests_failed++;
        $display("FAIL store_row%0d: got rd=%h addr=%h data=%h exp rd=%h addr=%h data=%h",
                 i, rd_val[i], mw_addr[i], mw_data[i], 8'(1 << i), 16'h0100 + 16'(i), word_of(i));
      end
    end
    tests_run++;
    if (n_done !== 1 || done_cyc !== 17) begin tests_failed++; $display("FAIL store_done: got n=%0d cyc=%0d exp n=1 cyc=17", n_done, done_cyc); end
    tests_run++;
    if (viol !== 0 || busy_after !== 0) begin tests_failed++; $display("FAIL store_misc: got viol=%0d busy=%0d exp 0 0", viol, busy_after); end
  endtask

  task automatic test_stall();
    run_op(1, 0, 16'h0100, 1, 4, -1, -1, -1);
    tests_run++;
    if (n_wr !== 8 || n_mr !== 8) begin tests_failed++; $display("FAIL stall_ld_counts: got wr=%0d mr=%0d exp 8 8", n_wr, n_mr); end
    tests_run++;
    if (wr_cyc[0] !== 3 || wr_cyc[1] !== 10 || wr_cyc[7] !== 28 || wr_cl[1] !== 16'h2222) begin
      tests_failed++;
      $display("FAIL stall_ld_cycles: got %0d %0d %0d cl1=%h exp 3 10 28 cl1=2222", wr_cyc[0], wr_cyc[1], wr_cyc[7], wr_cl[1]);
    end
    tests_run++;
    if (done_cyc !== 29 || n_done !== 1) begin tests_failed++; $display("FAIL stall_ld_done: got n=%0d cyc=%0d exp n=1 cyc=29", n_done, done_cyc); end
    run_op(0, 1, 16'h0100, -1, 0, 2, -1, -1);
    tests_run++;
    if (n_mw !== 8 || n_rd !== 8 || stall_bad !== 0) begin tests_failed++; $display("FAIL stall_st_counts: got mw=%0d rd=%0d bad=%0d exp 8 8 0", n_mw, n_rd, stall_bad); end
    tests_run++;
    if (mw_addr[2] !== 16'h0102 || mw_data[2] !== 16'h3333 || mw_data[3] !== 16'h4444) begin
      tests_failed++;
      $display("FAIL stall_st_data: got %h %h %h exp 0102 3333 4444", mw_addr[2], mw_data[2], mw_data[3]);
    end
    tests_run++;
    if (done_cyc !== 20 || n_done !== 1) begin tests_failed++; $display("FAIL stall_st_done: got n=%0d cyc=%0d exp n=1 cyc=20", n_done, done_cyc); end
  endtask

  task automatic test_simultaneous();
    run_op(1, 1, 16'h0100, -1, 0, -1, 5, -1);
    tests_run++;
    if (n_wr !== 8 || n_rd !== 0 || n_mw !== 0) begin tests_failed++; $display("FAIL simul_kind: got wr=%0d rd=%0d mw=%0d exp 8 0 0", n_wr, n_rd, n_mw); end
    tests_run++;
    if (n_done !== 1 || done_cyc !== 25) begin tests_failed++; $display("FAIL simul_done: got n=%0d cyc=%0d exp n=1 cyc=25", n_done, done_cyc); end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_a [8];
    exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
    exp_a[4] = 16'h0002; exp_a[5] = 16'h0003; exp_a[6] = 16'h0004; exp_a[7] = 16'h0005;
    run_op(1, 0, 16'hFFFE, -1, 0, -1, -1, -1);
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (mr_addr[i] !== exp_a[i]) begin tests_failed++; $display("FAIL wrap_addr%0d: got %h exp %h", i, mr_addr[i], exp_a[i]); end
    end
    tests_run++;
    if (done_cyc !== 25) begin tests_failed++; $display("FAIL wrap_done: got %0d exp 25", done_cyc); end
  endtask

  task automatic test_reset_mid();
    run_op(1, 0, 16'h0100, 3, 50, -1, -1, 11);
    tests_run++;
    if (snap !== 10'b0) begin tests_failed++; $display("FAIL rstmid_outputs: got %b exp 0", snap); end
    tests_run++;
    if (n_done !== 0 || n_wr !== 3) begin tests_failed++; $display("FAIL rstmid_abort: got done=%0d wr=%0d exp 0 3", n_done, n_wr); end
    run_op(1, 0, 16'h0200, -1, 0, -1, -1, -1);
    tests_run++;
    if (wr_val[0] !== 8'h01 || wr_cyc[0] !== 3 || mr_addr[0] !== 16'h0200 || done_cyc !== 25) begin
      tests_failed++;
      $display("FAIL rstmid_restart: got wr=%h cyc=%0d addr=%h done=%0d exp 01 3 0200 25", wr_val[0], wr_cyc[0], mr_addr[0], done_cyc);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) arr[i] = '0;
    test_reset();
    test_load();
    test_store_back_to_back();
    test_stall();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/clause_bin_loader.md
# clause_bin_loader

Sequencer that moves one clause bin between external bin memory and the clause array. A load copies `NUM_CLAUSES` clauses, with their lengths, from memory into the array through its one-hot write port. A store reads the clauses back through the one-hot read port and writes them to memory. The block sits between the bin manager and the clause array and is the sole driver of the array's `wr_i`, `rd_i`, `clause_i` and `clause_len_i`.

## Interface
- `NUM_CLAUSES`, 8, clauses per bin (array rows); one-hot strobe width.
- `NUM_VARS`, 8, variables per clause; each clause word is `NUM_VARS*2` bits.
- `WIDTH_C_LEN`, 4, clause length width.
- `WIDTH_ADDR`, 16, memory word address width.

Ports:
- `clk` in 1: clock. One clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `start_load_i` in 1: single-cycle request to load a bin.
- `start_store_i` in 1: single-cycle request to store a bin.
- `base_addr_i` in `WIDTH_ADDR`: bin base address, latched on an accepted start.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: single-cycle completion pulse.
- `mem_rd_o` out 1: memory read request, asserted for one cycle.
- `mem_addr_o` out `WIDTH_ADDR`: memory address for reads and writes.
- `mem_valid_i` in 1: read data valid.
- `mem_data_i` in `NUM_VARS*2`: clause word read from memory.
- `mem_len_i` in `WIDTH_C_LEN`: clause length read from memory.
- `mem_wr_o` out 1: memory write request, held until accepted.
- `mem_wdata_o` out `NUM_VARS*2`: clause word written to memory.
- `mem_ready_i` in 1: write accepted in any cycle where it is high together with `mem_wr_o`.
- `wr_o` out `NUM_CLAUSES`: one-hot array write strobe.
- `rd_o` out `NUM_CLAUSES`: one-hot array read strobe.
- `clause_o` out `NUM_VARS*2`: clause word driven to the array.
- `clause_len_o` out `WIDTH_C_LEN`: clause length driven to the array.
- `clause_i` in `NUM_VARS*2`: clause word from the array, valid combinationally while `rd_o` is set.

## Operation
- States: IDLE, LD_REQ, LD_WAIT, LD_WR, ST_RD, ST_WR, DONE. Clause index `k` is registered, `$clog2(NUM_CLAUSES)` bits.
- IDLE:
  - `start_load_i` moves to LD_REQ; `start_store_i` moves to ST_RD.
  - If both are high in the same cycle, load wins and the store request is dropped.
  - On an accepted start, `k` is set to 0 and `base_addr_i` is latched.
  - Starts received in any other state are ignored, with no queuing.
- `mem_addr_o` = latched base + `k`, modulo 2^`WIDTH_ADDR` (wraps silently). It is driven in every non-IDLE state and is 0 in IDLE.
- LD_REQ: `mem_rd_o` is high for one cycle, then the state moves to LD_WAIT.
- LD_WAIT: waits indefinitely for `mem_valid_i`. When it arrives, `mem_data_i` and `mem_len_i` are registered and the state moves to LD_WR. `mem_valid_i` is ignored in every other state.
- LD_WR:
  - For one cycle, `wr_o` = 1<<`k` and `clause_o`/`clause_len_o` = the registered data.
  - A length of 0 is written unchanged.
  - If `k`==`NUM_CLAUSES`-1 the state moves to DONE; otherwise `k`++ and the state moves to LD_REQ.
- ST_RD: for one cycle, `rd_o` = 1<<`k`; `clause_i` is registered at the end of that cycle, then the state moves to ST_WR.
- ST_WR:
  - `mem_wr_o` is high and `mem_wdata_o` holds the registered word until `mem_ready_i` is seen.
  - In the accepting cycle: if `k` is last, move to DONE; otherwise `k`++ and move to ST_RD.
  - Lengths are not stored.
- DONE: `done_o` is high for one cycle, then the state returns to IDLE.
- `wr_o` and `rd_o` are never nonzero in the same cycle, and each has at most one bit set.
- `clause_o` and `clause_len_o` are 0 outside LD_WR.

## Timing
- Reset:
  - State goes to IDLE and `k` to 0.
  - All outputs are 0: `busy_o`, `done_o`, `mem_rd_o`, `mem_wr_o`, `mem_addr_o`, `mem_wdata_o`, `wr_o`, `rd_o`, `clause_o`, `clause_len_o`.
  - A reset mid-operation aborts immediately: no `done_o`, and no further strobes in the cycle after reset.
- Start is accepted in cycle 0 and `busy_o` rises in cycle 1.
- Load: 3 cycles per clause plus memory stall cycles. With `mem_valid_i` arriving 1 cycle after `mem_rd_o`, clause `k` is written in cycle 3k+3 and `done_o` pulses in cycle 3N+1 (cycle 25 for N=8).
- Store: 2 cycles per clause plus write stall cycles. With `mem_ready_i` tied high, `done_o` pulses in cycle 2N+1 (cycle 17 for N=8).
- `busy_o` falls in the cycle after `done_o`. A new start is accepted in that same cycle.

## Test plan
- Load, memory latency 1, base 0x0100, word i = 0x1111*(i+1), length i: `wr_o` steps 0x01..0x80 in cycles 3,6,…,24; clause/length match per row; `done_o` at cycle 25 only.
- Store after load, `mem_ready_i` high: `rd_o` steps 0x01..0x80; `mem_wr_o` addresses 0x0100..0x0107 carry the loaded words in order; `done_o` at cycle 17.
- Backpressure and stall: `mem_valid_i` delayed 4 cycles; `mem_ready_i` low for 3 cycles on clause 2. Outputs hold steady during stalls; no duplicate `wr_o`, `rd_o` or write; `done_o` delayed by exactly the stall count.
- Simultaneous `start_load_i`+`start_store_i` in IDLE: a load runs. A `start_store_i` pulsed mid-load is ignored, so exactly one `done_o` is seen.
- Base 0xFFFE: addresses are 0xFFFE, 0xFFFF, 0x0000 … 0x0005.
- `rst` asserted in LD_WAIT of clause 3: the next cycle shows all outputs 0, `busy_o` 0 and no `done_o`; a following load starts again from `k`=0.
